// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator on the system clock, paced by a pixel clock-enable.
// Every output is registered and describes the current (h, v) raster position.
module vga_timing_gen #(
    parameter int unsigned PIX_DIV = 4,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned H_ACT   = 640,
    parameter int unsigned H_FP    = 16,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 29,
    parameter int unsigned V_ACT   = 480,
    parameter int unsigned V_FP    = 10,
    parameter logic        H_POL   = 1'b0,
    parameter logic        V_POL   = 1'b0,
    parameter int unsigned TILE_W  = 80,
    parameter int unsigned TILE_H  = 60,
    parameter int unsigned TILE_XB = 3,
    parameter int unsigned TILE_YB = 3,
    parameter int unsigned CW      = 11
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               en,
    output logic               pix_ce,
    output logic               hs,
    output logic               vs,
    output logic               de,
    output logic [CW-1:0]      col,
    output logic [CW-1:0]      row,
    output logic [TILE_XB-1:0] tile_x,
    output logic [TILE_YB-1:0] tile_y,
    output logic               line_start,
    output logic               frame_start
);

    localparam int unsigned H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int unsigned V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int unsigned DW    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int unsigned TXW   = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int unsigned TYW   = (TILE_H > 1) ? $clog2(TILE_H) : 1;

    localparam logic [DW-1:0]  DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [CW-1:0]  H_LAST   = CW'(H_TOT - 1);
    localparam logic [CW-1:0]  V_LAST   = CW'(V_TOT - 1);
    localparam logic [CW-1:0]  HS_END   = CW'(H_SYNC);
    localparam logic [CW-1:0]  VS_END   = CW'(V_SYNC);
    localparam logic [CW-1:0]  HA_BEG   = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0]  HA_END   = CW'(H_SYNC + H_BP + H_ACT - 1);
    localparam logic [CW-1:0]  VA_BEG   = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0]  VA_END   = CW'(V_SYNC + V_BP + V_ACT - 1);
    localparam logic [TXW-1:0] TX_LAST  = TXW'(TILE_W - 1);
    localparam logic [TYW-1:0] TY_LAST  = TYW'(TILE_H - 1);

    logic [DW-1:0]      div, div_n, div_step;
    logic [CW-1:0]      h, h_n, v, v_n, h_inc, v_inc;
    logic [TXW-1:0]     tx_sub, tx_sub_n;
    logic [TYW-1:0]     ty_sub, ty_sub_n;
    logic               pix_ce_n, hs_n, vs_n, de_n, line_start_n, frame_start_n;
    logic [CW-1:0]      col_n, row_n;
    logic [TILE_XB-1:0] tile_x_n;
    logic [TILE_YB-1:0] tile_y_n;
    logic               h_wrap, v_wrap, ha, va, ha_inc, va_inc;

    // Raster position the counters move to on the next pixel strobe.
    assign div_step = (div == DIV_LAST) ? '0 : div + 1'b1;
    assign h_wrap   = (h == H_LAST);
    assign v_wrap   = (v == V_LAST);
    assign h_inc    = h_wrap ? '0 : h + 1'b1;
    assign v_inc    = !h_wrap ? v : (v_wrap ? '0 : v + 1'b1);
    assign ha       = (h >= HA_BEG) && (h <= HA_END);
    assign va       = (v >= VA_BEG) && (v <= VA_END);
    assign ha_inc   = (h_inc >= HA_BEG) && (h_inc <= HA_END);
    assign va_inc   = (v_inc >= VA_BEG) && (v_inc <= VA_END);

    always_comb begin
        div_n         = div;
        pix_ce_n      = pix_ce;
        h_n           = h;
        v_n           = v;
        tx_sub_n      = tx_sub;
        ty_sub_n      = ty_sub;
        hs_n          = hs;
        vs_n          = vs;
        de_n          = de;
        col_n         = col;
        row_n         = row;
        tile_x_n      = tile_x;
        tile_y_n      = tile_y;
        line_start_n  = 1'b0;
        frame_start_n = 1'b0;
        if (!en) begin
            div_n    = '0;
            pix_ce_n = 1'b0;
            h_n      = H_LAST;
            v_n      = V_LAST;
            tx_sub_n = '0;
            ty_sub_n = '0;
            hs_n     = ~H_POL;
            vs_n     = ~V_POL;
            de_n     = 1'b0;
            col_n    = '1;
            row_n    = '1;
            tile_x_n = '0;
            tile_y_n = '0;
        end else begin
            div_n    = div_step;
            pix_ce_n = (div_step == DIV_LAST);
            if (pix_ce) begin
                h_n           = h_inc;
                v_n           = v_inc;
                hs_n          = (h_inc < HS_END) ? H_POL : ~H_POL;
                vs_n          = (v_inc < VS_END) ? V_POL : ~V_POL;
                de_n          = ha_inc && va_inc;
                col_n         = ha_inc ? h_inc - HA_BEG : '1;
                row_n         = va_inc ? v_inc - VA_BEG : '1;
                line_start_n  = h_wrap;
                frame_start_n = h_wrap && v_wrap;
                // Tile column restarts at the first active pixel of every line.
                if (!ha_inc || !ha) begin
                    tx_sub_n = '0;
                    tile_x_n = '0;
                end else if (tx_sub == TX_LAST) begin
                    tx_sub_n = '0;
                    tile_x_n = tile_x + 1'b1;
                end else begin
                    tx_sub_n = tx_sub + 1'b1;
                end
                // Tile row only moves on line boundaries.
                if (!va_inc) begin
                    ty_sub_n = '0;
                    tile_y_n = '0;
                end else if (h_wrap) begin
                    if (!va) begin
                        ty_sub_n = '0;
                        tile_y_n = '0;
                    end else if (ty_sub == TY_LAST) begin
                        ty_sub_n = '0;
                        tile_y_n = tile_y + 1'b1;
                    end else begin
                        ty_sub_n = ty_sub + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div         <= '0;
            pix_ce      <= 1'b0;
            h           <= H_LAST;
            v           <= V_LAST;
            tx_sub      <= '0;
            ty_sub      <= '0;
            hs          <= ~H_POL;
            vs          <= ~V_POL;
            de          <= 1'b0;
            col         <= '1;
            row         <= '1;
            tile_x      <= '0;
            tile_y      <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= div_n;
            pix_ce      <= pix_ce_n;
            h           <= h_n;
            v           <= v_n;
            tx_sub      <= tx_sub_n;
            ty_sub      <= ty_sub_n;
            hs          <= hs_n;
            vs          <= vs_n;
            de          <= de_n;
            col         <= col_n;
            row         <= row_n;
            tile_x      <= tile_x_n;
            tile_y      <= tile_y_n;
            line_start  <= line_start_n;
            frame_start <= frame_start_n;
        end
    end

endmodule
